// File: rtl/turn_signal_seq.sv
// Sequential tail-light controller: running-fill turn pattern, hazard flash and brake overlay.
// Lamps are decoded from registered state only; one pattern step every STEP_CYCLES clocks.
module turn_signal_seq #(
   parameter int LAMPS       = 3,
   parameter int STEP_CYCLES = 4,
   parameter int CNT_W       = $clog2(STEP_CYCLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             turn_left,
   input  logic             turn_right,
   input  logic             hazard,
   input  logic             brake,
   output logic [LAMPS-1:0] left_lamp,
   output logic [LAMPS-1:0] right_lamp,
   output logic             step_tick
);

   localparam int PH_W = $clog2(LAMPS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(LAMPS);
   localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);

   typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_t;

   mode_t            mode, mode_nxt, req_mode;
   logic [PH_W-1:0]  phase, phase_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             tick_nxt;
   logic             brake_q;

   // Running fill: the lowest `ph` lamps are lit.
   function automatic logic [LAMPS-1:0] fill(input logic [PH_W-1:0] ph);
      logic [LAMPS-1:0] f;
      f = '0;
      for (int i = 0; i < LAMPS; i++) f[i] = (i < int'(ph));
      return f;
   endfunction

   always_comb begin
      req_mode = IDLE;
      if (hazard || (turn_left && turn_right)) req_mode = HAZARD;
      else if (turn_left)                      req_mode = LEFT;
      else if (turn_right)                     req_mode = RIGHT;
   end

   always_comb begin
      mode_nxt  = mode;
      phase_nxt = phase;
      cnt_nxt   = cnt + 1'b1;
      tick_nxt  = 1'b0;
      if (req_mode != mode) begin
         mode_nxt  = req_mode;
         phase_nxt = '0;
         cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
         cnt_nxt = '0;
         case (mode)
            LEFT, RIGHT: begin
               phase_nxt = (phase == PH_LAST) ? '0 : phase + 1'b1;
               tick_nxt  = 1'b1;
            end
            HAZARD: begin
               phase_nxt = (phase == '0) ? PH_ONE : '0;
               tick_nxt  = 1'b1;
            end
            default: phase_nxt = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode      <= IDLE;
         phase     <= '0;
         cnt       <= '0;
         step_tick <= 1'b0;
         brake_q   <= 1'b0;
      end else begin
         mode      <= mode_nxt;
         phase     <= phase_nxt;
         cnt       <= cnt_nxt;
         step_tick <= tick_nxt;
         brake_q   <= brake;
      end
   end

   // Output decode: brake overlay lights the non-turning side; hazard overrides brake.
   always_comb begin
      left_lamp  = {LAMPS{brake_q}};
      right_lamp = {LAMPS{brake_q}};
      case (mode)
         LEFT:    left_lamp  = fill(phase);
         RIGHT:   right_lamp = fill(phase);
         HAZARD: begin
            left_lamp  = {LAMPS{phase == PH_ONE}};
            right_lamp = {LAMPS{phase == PH_ONE}};
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: two instances (3 lamps/4 cycles, 5 lamps/2 cycles) on shared inputs,
// checked every cycle against a mode-age model plus hand-computed directed expectations.
module tb_turn_signal_seq;

   logic clk = 1'b0;
   logic rst, turn_left, turn_right, hazard, brake;
   logic [2:0] a_left, a_right;
   logic [4:0] b_left, b_right;
   logic       a_tick, b_tick;

   int n_vec  = 0;
   int n_fail = 0;

   // Model: mode = request seen at the previous edge, age = cycles spent in that mode.
   int m_mode  = 0;   // 0 idle, 1 left, 2 right, 3 hazard
   int m_age   = 0;
   bit m_brk   = 1'b0;
   bit m_valid = 1'b0;

   always #5 clk = ~clk;

   turn_signal_seq #(.LAMPS(3), .STEP_CYCLES(4)) dut_a (
      .clk(clk), .rst(rst), .turn_left(turn_left), .turn_right(turn_right),
      .hazard(hazard), .brake(brake),
      .left_lamp(a_left), .right_lamp(a_right), .step_tick(a_tick));

   turn_signal_seq #(.LAMPS(5), .STEP_CYCLES(2)) dut_b (
      .clk(clk), .rst(rst), .turn_left(turn_left), .turn_right(turn_right),
      .hazard(hazard), .brake(brake),
      .left_lamp(b_left), .right_lamp(b_right), .step_tick(b_tick));

   always @(posedge clk) begin
      int req;
      req = (hazard || (turn_left && turn_right)) ? 3 : turn_left ? 1 : turn_right ? 2 : 0;
      if (rst) begin
         m_mode = 0; m_age = 0; m_brk = 1'b0; m_valid = 1'b1;
      end else begin
         if (req != m_mode) begin
            m_mode = req; m_age = 0;
         end else begin
            m_age++;
         end
         m_brk = brake;
      end
   end

   function automatic logic [7:0] ones(input int l);
      return 8'((1 << l) - 1);
   endfunction

   function automatic logic [7:0] exp_lamp(input int side, input int l, input int s);
      int ph;
      logic [7:0] brk_mask;
      brk_mask = m_brk ? ones(l) : 8'd0;
      if (m_mode == 3) begin
         ph = (m_age / s) % 2;
         return (ph == 1) ? ones(l) : 8'd0;
      end
      if (m_mode == 1 || m_mode == 2) begin
         ph = (m_age / s) % (l + 1);
         return (m_mode == side) ? ones(ph) : brk_mask;
      end
      return brk_mask;
   endfunction

   function automatic logic [7:0] exp_tick(input int s);
      return (m_mode != 0 && m_age > 0 && (m_age % s) == 0) ? 8'd1 : 8'd0;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("a_left",  {5'b0, a_left},  exp_lamp(1, 3, 4));
         chk("a_right", {5'b0, a_right}, exp_lamp(2, 3, 4));
         chk("a_tick",  {7'b0, a_tick},  exp_tick(4));
         chk("b_left",  {3'b0, b_left},  exp_lamp(1, 5, 2));
         chk("b_right", {3'b0, b_right}, exp_lamp(2, 5, 2));
         chk("b_tick",  {7'b0, b_tick},  exp_tick(2));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; turn_left = 1'b0; turn_right = 1'b0; hazard = 1'b0; brake = 1'b0;

      // Reset held two cycles, then first cycle after release.
      step(2);
      chk("rst_left",  {5'b0, a_left},  8'b000);
      chk("rst_right", {5'b0, a_right}, 8'b000);
      chk("rst_tick",  {7'b0, a_tick},  8'd0);
      rst = 1'b0;
      step(1);
      chk("rel_left",  {5'b0, a_left},  8'b000);
      chk("rel_right", {5'b0, a_right}, 8'b000);
      step(2);

      // Left running fill on both instances.
      turn_left = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         step(1);
         case (k)
            1, 4:   begin chk("l_dark", {5'b0, a_left}, 8'b000); chk("l_dtick", {7'b0, a_tick}, 8'd0); end
            5:      begin chk("l_p1",  {5'b0, a_left}, 8'b001); chk("l_t5",  {7'b0, a_tick}, 8'd1); end
            8:      chk("l_hold", {5'b0, a_left}, 8'b001);
            9:      begin chk("l_p2",  {5'b0, a_left}, 8'b011); chk("l_t9",  {7'b0, a_tick}, 8'd1); end
            13:     chk("l_p3",  {5'b0, a_left}, 8'b111);
            17:     begin chk("l_wrap", {5'b0, a_left}, 8'b000); chk("l_t17", {7'b0, a_tick}, 8'd1); end
            21:     chk("l_p1b", {5'b0, a_left}, 8'b001);
            default: ;
         endcase
         if (k == 3)  begin chk("b_p1", {3'b0, b_left}, 8'b00001); chk("b_t3", {7'b0, b_tick}, 8'd1); end
         if (k == 11) chk("b_full", {3'b0, b_left}, 8'b11111);
         if (k == 13) chk("b_wrap", {3'b0, b_left}, 8'b00000);
         if (k == 9)  chk("l_right", {5'b0, a_right}, 8'b000);
      end
      turn_left = 1'b0;
      step(1);
      chk("drop_left", {5'b0, a_left}, 8'b000);
      step(3);

      // Hazard with brake held: brake ignored.
      hazard = 1'b1; brake = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         step(1);
         if (k == 4)  chk("hz_dark", {5'b0, a_right}, 8'b000);
         if (k == 5)  begin chk("hz_on_l", {5'b0, a_left}, 8'b111); chk("hz_on_r", {5'b0, a_right}, 8'b111); end
         if (k == 9)  chk("hz_off", {5'b0, a_left}, 8'b000);
         if (k == 13) chk("hz_on2", {5'b0, a_right}, 8'b111);
      end
      hazard = 1'b0; brake = 1'b0;
      step(3);

      // Left+right together behaves as hazard.
      turn_left = 1'b1; turn_right = 1'b1;
      step(5);
      chk("lr_hz_l", {5'b0, a_left},  8'b111);
      chk("lr_hz_r", {5'b0, a_right}, 8'b111);
      turn_left = 1'b0; turn_right = 1'b0;
      step(3);

      // Right turn with brake overlay on the left side.
      turn_right = 1'b1;
      step(6);
      brake = 1'b1;
      step(1);
      chk("brk_left",  {5'b0, a_left},  8'b111);
      chk("brk_right", {5'b0, a_right}, 8'b001);
      step(2);
      chk("brk_step",  {5'b0, a_right}, 8'b011);
      chk("brk_tick",  {7'b0, a_tick},  8'd1);
      brake = 1'b0;
      step(1);
      chk("unbrk_left", {5'b0, a_left}, 8'b000);
      turn_right = 1'b0;
      step(3);

      // Left at phase 2, switch straight to right.
      turn_left = 1'b1;
      step(9);
      chk("sw_pre", {5'b0, a_left}, 8'b011);
      turn_left = 1'b0; turn_right = 1'b1;
      step(1);
      chk("sw_left",  {5'b0, a_left},  8'b000);
      chk("sw_right", {5'b0, a_right}, 8'b000);
      step(3);
      chk("sw_r_dark", {5'b0, a_right}, 8'b000);
      step(1);
      chk("sw_r_p1", {5'b0, a_right}, 8'b001);
      turn_right = 1'b0;
      step(3);

      // Reset mid-sequence while fully lit.
      turn_left = 1'b1;
      step(13);
      chk("mr_full", {5'b0, a_left}, 8'b111);
      rst = 1'b1;
      step(1);
      chk("mr_left", {5'b0, a_left}, 8'b000);
      chk("mr_tick", {7'b0, a_tick}, 8'd0);
      chk("mr_b",    {3'b0, b_left}, 8'b00000);
      rst = 1'b0;
      step(1);
      chk("mr_rel", {5'b0, a_left}, 8'b000);
      step(4);
      chk("mr_p1", {5'b0, a_left}, 8'b001);
      turn_left = 1'b0;
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
